// File: rtl/mux4_rr_arbiter_if.sv
// Request/data/grant bundle between four requesters and the shared 4:1 mux arbiter.
// The requester side uses the master modport; the arbiter uses the slave modport.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic [3:0] gnt;
    logic       sel1;
    logic       sel2;
    logic       y;
    logic       busy;

    modport master (
        output req, a, b, c, d,
        input  gnt, sel1, sel2, y, busy
    );

    modport slave (
        input  req, a, b, c, d,
        output gnt, sel1, sel2, y, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Sequencer for a shared 4:1 single-bit mux: round-robin grant with bounded hold, registered y.
// Define MUX_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest); ptr then stays at 0.
//
// state | meaning
// IDLE  | no owner; gnt=0, busy=0, y driven low, sel keeps its last value
// BUSY  | one requester owns the mux; y samples its data every cycle
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    mux4_rr_arbiter_if.slave bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             y_q, y_d;
    logic             busy_q, busy_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic [3:0] din;
    logic [1:0] scan_start;
    logic [2:0] win;
    logic       release_now;

    assign din = {bus.d, bus.c, bus.b, bus.a};

    // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        release_now = (!bus.req[sel_q]) || (hold_q == HOLD_LAST);
`ifdef MUX_ARB_FIXED_PRIO_EN
        scan_start = 2'd0;
`else
        scan_start = (state_q == IDLE) ? ptr_q : sel_q + 2'd1;
`endif
        win = pick(bus.req, scan_start);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        y_d     = y_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;

        case (state_q)
            IDLE: begin
                y_d = 1'b0;
                if (win[2]) begin
                    state_d = BUSY;
                    gnt_d   = 4'b0001 << win[1:0];
                    sel_d   = win[1:0];
                    hold_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            BUSY: begin
                // sel_q is the owner index, so it also drives the mux
                y_d    = din[sel_q];
                hold_d = hold_q + CNT_W'(1);
                if (release_now) begin
`ifndef MUX_ARB_FIXED_PRIO_EN
                    ptr_d = sel_q + 2'd1;
`endif
                    if (win[2]) begin
                        gnt_d  = 4'b0001 << win[1:0];
                        sel_d  = win[1:0];
                        hold_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= 2'b00;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel1 = sel_q[1];
    assign bus.sel2 = sel_q[0];
    assign bus.y    = y_q;
    assign bus.busy = busy_q;

endmodule
